// File: rtl/rx_word_axis_packer.sv
// -----------------------------------------------------------------------------
// rx_word_axis_packer
//
// Purpose:
//   Takes a packet header (byte length) followed by 64-bit payload words and
//   forwards them onto an AXI-Stream master through an internal
//   first-word-fall-through FIFO. If the FIFO overflows or a packet is cut
//   short by a new header, the rest of the damaged packet is discarded and a
//   synthetic terminator word {tuser=1, tlast=1, tdata=0} closes it
//   downstream. Every damaged packet bumps a saturating counter.
//
// Ports:
//   clk                     - single clock, rising edge
//   rstn                    - asynchronous active-low reset
//   pkt_header_valid_strobe - one-cycle pulse, start of a new packet
//   pkt_len[15:0]           - packet length in bytes, valid with the header
//   word_in[63:0]           - payload word
//   word_in_strobe          - one-cycle qualifier for word_in
//   m_axis_tdata[63:0]      - output word
//   m_axis_tvalid           - output valid (FIFO not empty)
//   m_axis_tready           - downstream ready
//   m_axis_tlast            - final word of a packet
//   m_axis_tuser            - set only on a synthetic terminator word
//   fifo_level[FIFO_AW:0]   - current FIFO occupancy
//   overflow_cnt[CNT_W-1:0] - saturating count of dropped/aborted packets
// -----------------------------------------------------------------------------
module rx_word_axis_packer #(
  parameter int FIFO_AW = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               pkt_header_valid_strobe,
  input  logic [15:0]        pkt_len,
  input  logic [63:0]        word_in,
  input  logic               word_in_strobe,
  output logic [63:0]        m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [CNT_W-1:0]   overflow_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [FIFO_AW:0]   LVL_ZERO   = {(FIFO_AW+1){1'b0}};
  localparam logic [FIFO_AW:0]   LVL_ONE    = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   LVL_FULL   = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW-1:0] PTR_ZERO   = {FIFO_AW{1'b0}};
  localparam logic [FIFO_AW-1:0] PTR_ONE    = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  // FIFO entry layout: [65] err, [64] last, [63:0] data
  localparam logic [65:0]        TERM_ENTRY = {1'b1, 1'b1, 64'd0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2,
    ST_TERM = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [16:0]        num_word_q, num_word_d;
  logic [16:0]        index_q, index_d;
  logic               restart_q, restart_d;
  logic [CNT_W-1:0]   ovf_q, ovf_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic [65:0]        mem_q [DEPTH];

  logic [16:0]        hdr_num_word_s;
  logic [16:0]        idx_adv_s;
  logic               last_word_s;
  logic               full_s;
  logic               pop_s;
  logic               push_s;
  logic [65:0]        push_entry_s;
  logic               ovf_inc_s;
  logic [65:0]        head_s;

  // Word count rounded up; 17 bits so pkt_len near 65535 cannot wrap.
  assign hdr_num_word_s = ({1'b0, pkt_len} + 17'd7) >> 2'd3;
  assign last_word_s    = (index_q == (num_word_q - 17'd1));
  assign full_s         = (level_q == LVL_FULL);
  assign pop_s          = (level_q != LVL_ZERO) && m_axis_tready;

  // Packet state machine: decides what (if anything) is pushed this cycle.
  always_comb begin
    state_d      = state_q;
    num_word_d   = num_word_q;
    index_d      = index_q;
    restart_d    = restart_q;
    push_s       = 1'b0;
    push_entry_s = 66'd0;
    ovf_inc_s    = 1'b0;
    idx_adv_s    = index_q;

    case (state_q)
      ST_IDLE: begin
        // Words outside a packet and zero-length headers are ignored.
        if (pkt_header_valid_strobe && (pkt_len != 16'd0)) begin
          num_word_d = hdr_num_word_s;
          index_d    = 17'd0;
          restart_d  = 1'b0;
          state_d    = ST_RECV;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_RECV: begin
        if (pkt_header_valid_strobe) begin
          // Current packet is incomplete: close it before the new one starts.
          ovf_inc_s  = 1'b1;
          num_word_d = hdr_num_word_s;
          index_d    = 17'd0;
          if (!full_s) begin
            push_s       = 1'b1;
            push_entry_s = TERM_ENTRY;
            restart_d    = 1'b0;
            state_d      = (hdr_num_word_s == 17'd0) ? ST_IDLE : ST_RECV;
          end else begin
            restart_d    = 1'b1;
            state_d      = ST_TERM;
          end
        end else if (word_in_strobe) begin
          index_d = index_q + 17'd1;
          if (!full_s) begin
            push_s       = 1'b1;
            push_entry_s = {1'b0, last_word_s, word_in};
            state_d      = last_word_s ? ST_IDLE : ST_RECV;
          end else begin
            // The dropped word still counts toward the packet's span.
            ovf_inc_s    = 1'b1;
            restart_d    = 1'b0;
            state_d      = ST_TERM;
          end
        end else begin
          state_d = ST_RECV;
        end
      end

      ST_TERM: begin
        if (pkt_header_valid_strobe) begin
          // New packet waits behind the pending terminator.
          num_word_d = hdr_num_word_s;
          index_d    = 17'd0;
          if (!full_s) begin
            push_s       = 1'b1;
            push_entry_s = TERM_ENTRY;
            restart_d    = 1'b0;
            state_d      = (hdr_num_word_s == 17'd0) ? ST_IDLE : ST_RECV;
          end else begin
            restart_d    = 1'b1;
            state_d      = ST_TERM;
          end
        end else begin
          // Discarded words advance the index, saturating at the packet end.
          if (word_in_strobe && (index_q < num_word_q)) begin
            idx_adv_s = index_q + 17'd1;
          end else begin
            idx_adv_s = index_q;
          end
          index_d = idx_adv_s;
          if (!full_s) begin
            push_s       = 1'b1;
            push_entry_s = TERM_ENTRY;
            restart_d    = 1'b0;
            if (idx_adv_s >= num_word_q) begin
              state_d = ST_IDLE;
            end else if (restart_q) begin
              state_d = ST_RECV;
            end else begin
              state_d = ST_DROP;
            end
          end else begin
            state_d = ST_TERM;
          end
        end
      end

      ST_DROP: begin
        if (pkt_header_valid_strobe) begin
          num_word_d = hdr_num_word_s;
          index_d    = 17'd0;
          restart_d  = 1'b0;
          state_d    = (hdr_num_word_s == 17'd0) ? ST_IDLE : ST_RECV;
        end else if (word_in_strobe) begin
          idx_adv_s = index_q + 17'd1;
          index_d   = idx_adv_s;
          state_d   = (idx_adv_s >= num_word_q) ? ST_IDLE : ST_DROP;
        end else begin
          state_d = ST_DROP;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        restart_d = 1'b0;
      end
    endcase
  end

  // Overflow counter next value; holds at all-ones instead of wrapping.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_inc_s && (ovf_q != CNT_MAX)) begin
      ovf_d = ovf_q + CNT_ONE;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO pointer and occupancy next values; push is never issued when full.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      level_d = level_q + LVL_ONE;
    end else if (pop_s && !push_s) begin
      level_d = level_q - LVL_ONE;
    end else begin
      level_d = level_q;
    end
  end

  // Control and FIFO bookkeeping registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      num_word_q <= 17'd0;
      index_q    <= 17'd0;
      restart_q  <= 1'b0;
      ovf_q      <= CNT_ZERO;
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      level_q    <= LVL_ZERO;
    end else begin
      state_q    <= state_d;
      num_word_q <= num_word_d;
      index_q    <= index_d;
      restart_q  <= restart_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // FIFO storage; contents are only observed while the level is non-zero.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_entry_s;
    end
  end

  // Head entry falls through; outputs are forced to zero while empty so
  // reset shows an all-zero interface immediately.
  assign head_s        = mem_q[rd_ptr_q];
  assign m_axis_tvalid = (level_q != LVL_ZERO);
  assign m_axis_tdata  = m_axis_tvalid ? head_s[63:0] : 64'd0;
  assign m_axis_tlast  = m_axis_tvalid & head_s[64];
  assign m_axis_tuser  = m_axis_tvalid & head_s[65];
  assign fifo_level    = level_q;
  assign overflow_cnt  = ovf_q;

endmodule

// File: tb/tb_rx_word_axis_packer.sv
// -----------------------------------------------------------------------------
// tb_rx_word_axis_packer
//
// Self-checking bench. A packet-level reference model (remaining words,
// whether the packet is being kept, whether a terminator is owed, and a
// queue standing in for the FIFO) predicts the output stream; a compare
// process checks the DUT against it on every falling edge. Directed
// scenarios add hand-computed expectations, followed by random traffic.
// -----------------------------------------------------------------------------
module tb_rx_word_axis_packer;

  logic        clk;
  logic        rstn;
  logic        pkt_header_valid_strobe;
  logic [15:0] pkt_len;
  logic [63:0] word_in;
  logic        word_in_strobe;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [4:0]  fifo_level;
  logic [15:0] overflow_cnt;

  rx_word_axis_packer #(.FIFO_AW(4), .CNT_W(16)) dut (
    .clk                     (clk),
    .rstn                    (rstn),
    .pkt_header_valid_strobe (pkt_header_valid_strobe),
    .pkt_len                 (pkt_len),
    .word_in                 (word_in),
    .word_in_strobe          (word_in_strobe),
    .m_axis_tdata            (m_axis_tdata),
    .m_axis_tvalid           (m_axis_tvalid),
    .m_axis_tready           (m_axis_tready),
    .m_axis_tlast            (m_axis_tlast),
    .m_axis_tuser            (m_axis_tuser),
    .fifo_level              (fifo_level),
    .overflow_cnt            (overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [65:0] mq[$];
  int          rem;
  bit          good;
  bit          owe;
  int          mcnt;

  logic [65:0] beats[$];
  int          max_lvl;
  logic [63:0] da [0:31];
  logic [65:0] term_word;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    rem  = 0;
    good = 1'b1;
    owe  = 1'b0;
    mcnt = 0;
  endtask

  task automatic bump();
    if (mcnt < 65535) mcnt++;
  endtask

  // One clock of packet-level behaviour.
  task automatic model_step(input bit h, input logic [15:0] len, input bit w,
                            input logic [63:0] d, input bit rdy);
    bit full;
    bit pop;
    full = (mq.size() >= 16);
    pop  = (mq.size() != 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (h) begin
      if (!owe && good && rem > 0) begin
        bump();
        owe = 1'b1;
      end
      rem  = (int'(len) + 7) / 8;
      good = 1'b1;
      if (owe && !full) begin
        mq.push_back(term_word);
        owe = 1'b0;
      end
    end else if (w) begin
      if (owe) begin
        if (rem > 0) rem--;
        if (!full) begin
          mq.push_back(term_word);
          owe = 1'b0;
        end
      end else if (good && rem > 0) begin
        if (!full) begin
          mq.push_back({1'b0, 1'(rem == 1), d});
        end else begin
          bump();
          good = 1'b0;
          owe  = 1'b1;
        end
        rem--;
      end else if (rem > 0) begin
        rem--;
      end
    end else if (owe && !full) begin
      mq.push_back(term_word);
      owe = 1'b0;
    end
  endtask

  // Drive one cycle starting from a falling edge; ends on the next falling edge.
  task automatic step(input bit h, input logic [15:0] len, input bit w,
                      input logic [63:0] d, input bit rdy);
    pkt_header_valid_strobe = h;
    pkt_len                 = len;
    word_in_strobe          = w;
    word_in                 = d;
    m_axis_tready           = rdy;
    if (m_axis_tvalid && rdy) beats.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    @(posedge clk);
    model_step(h, len, w, d, rdy);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(1'b0, 16'd0, 1'b0, 64'd0, rdy);
  endtask

  task automatic do_reset();
    #2;
    rstn = 1'b0;
    model_clear();
    #1;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en && rstn) begin
      chk("level", 66'(fifo_level), 66'(mq.size()));
      chk("tvalid", 66'(m_axis_tvalid), 66'(mq.size() != 0));
      chk("ovf_cnt", 66'(overflow_cnt), 66'(mcnt));
      if (mq.size() != 0) chk("head_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, mq[0]);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    term_word = {1'b1, 1'b1, 64'd0};
    for (int i = 0; i < 32; i++) da[i] = {$urandom, $urandom};
    rstn = 1'b0;
    pkt_header_valid_strobe = 1'b0;
    pkt_len = 16'd0;
    word_in = 64'd0;
    word_in_strobe = 1'b0;
    m_axis_tready = 1'b0;
    model_clear();
    max_lvl = 0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 66'(m_axis_tvalid), 66'd0);
    chk("rst_level", 66'(fifo_level), 66'd0);
    chk("rst_ovf", 66'(overflow_cnt), 66'd0);
    chk("rst_out", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, 66'd0);
    rstn = 1'b1;
    chk_en = 1'b1;

    // 20-byte packet, 3 words, free-flowing sink
    beats.delete();
    step(1'b1, 16'd20, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 1'b1, da[i], 1'b1);
    idle(4, 1'b1);
    chk("A_nbeats", 66'(beats.size()), 66'd3);
    if (beats.size() == 3)
      for (int i = 0; i < 3; i++) chk("A_beat", beats[i], {1'b0, 1'(i == 2), da[i]});
    chk("A_ovf", 66'(overflow_cnt), 66'd0);

    // 200-byte packet into a stalled sink: 16 kept, word 17 dropped
    do_reset();
    step(1'b1, 16'd200, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 25; i++) step(1'b0, 16'd0, 1'b1, da[i], 1'b0);
    chk("B_level", 66'(fifo_level), 66'd16);
    chk("B_ovf", 66'(overflow_cnt), 66'd1);
    beats.delete();
    idle(24, 1'b1);
    chk("B_nbeats", 66'(beats.size()), 66'd17);
    if (beats.size() == 17) begin
      for (int i = 0; i < 16; i++) chk("B_beat", beats[i], {2'b00, da[i]});
      chk("B_term", beats[16], {1'b1, 1'b1, 64'd0});
    end
    chk("B_ovf_end", 66'(overflow_cnt), 66'd1);

    // Header cuts a packet short: terminator sits between the two packets
    do_reset();
    beats.delete();
    step(1'b1, 16'd24, 1'b0, 64'd0, 1'b1);
    step(1'b0, 16'd0, 1'b1, da[0], 1'b1);
    step(1'b0, 16'd0, 1'b1, da[1], 1'b1);
    step(1'b1, 16'd8, 1'b0, 64'd0, 1'b1);
    step(1'b0, 16'd0, 1'b1, da[2], 1'b1);
    idle(5, 1'b1);
    chk("C_nbeats", 66'(beats.size()), 66'd4);
    if (beats.size() == 4) begin
      chk("C_w0", beats[0], {2'b00, da[0]});
      chk("C_w1", beats[1], {2'b00, da[1]});
      chk("C_term", beats[2], {1'b1, 1'b1, 64'd0});
      chk("C_w2", beats[3], {1'b0, 1'b1, da[2]});
    end
    chk("C_ovf", 66'(overflow_cnt), 66'd1);

    // Zero-length header: following words go nowhere
    do_reset();
    beats.delete();
    step(1'b1, 16'd0, 1'b0, 64'd0, 1'b1);
    step(1'b0, 16'd0, 1'b1, da[3], 1'b1);
    step(1'b0, 16'd0, 1'b1, da[4], 1'b1);
    idle(3, 1'b1);
    chk("D_nbeats", 66'(beats.size()), 66'd0);
    chk("D_level", 66'(fifo_level), 66'd0);

    // tready toggling every cycle over a 64-byte packet
    do_reset();
    beats.delete();
    max_lvl = 0;
    step(1'b1, 16'd64, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 16'd0, 1'b1, da[i+8], 1'(i % 2));
    for (int i = 0; i < 16; i++) step(1'b0, 16'd0, 1'b0, 64'd0, 1'(i % 2));
    chk("E_nbeats", 66'(beats.size()), 66'd8);
    if (beats.size() == 8)
      for (int i = 0; i < 8; i++) chk("E_beat", beats[i], {1'b0, 1'(i == 7), da[i+8]});
    chk("E_maxlvl_le8", 66'(max_lvl <= 8), 66'd1);

    // Asynchronous reset with 5 words buffered, then a clean packet
    do_reset();
    step(1'b1, 16'd64, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'd0, 1'b1, da[i], 1'b0);
    idle(1, 1'b0);
    chk("F_level_pre", 66'(fifo_level), 66'd5);
    chk("F_tvalid_pre", 66'(m_axis_tvalid), 66'd1);
    #2;
    rstn = 1'b0;
    model_clear();
    #1;
    chk("F_tvalid_async", 66'(m_axis_tvalid), 66'd0);
    chk("F_level_async", 66'(fifo_level), 66'd0);
    @(negedge clk);
    rstn = 1'b1;
    beats.delete();
    step(1'b1, 16'd16, 1'b0, 64'd0, 1'b1);
    step(1'b0, 16'd0, 1'b1, da[20], 1'b1);
    step(1'b0, 16'd0, 1'b1, da[21], 1'b1);
    idle(4, 1'b1);
    chk("F_nbeats", 66'(beats.size()), 66'd2);
    if (beats.size() == 2) begin
      chk("F_w0", beats[0], {2'b00, da[20]});
      chk("F_w1", beats[1], {1'b0, 1'b1, da[21]});
    end

    // Random traffic against the model
    do_reset();
    begin
      int p;
      bit h;
      bit w;
      int r;
      logic [15:0] len;
      p = 100;
      for (int c = 0; c < 4000; c++) begin
        if (c % 200 == 0) begin
          r = int'($urandom_range(0, 3));
          p = (r == 0) ? 0 : (r == 1) ? 30 : (r == 2) ? 70 : 100;
        end
        if (c == 2000) do_reset();
        h = ($urandom_range(0, 23) == 0);
        w = ($urandom_range(0, 1) == 1);
        r = int'($urandom_range(0, 7));
        if (r == 0) len = 16'd0;
        else if (r < 6) len = 16'($urandom_range(1, 64));
        else len = 16'($urandom_range(65, 250));
        step(h, len, w, {$urandom, $urandom}, ($urandom_range(0, 99) < p));
      end
      idle(40, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_word_axis_packer.md
RX_WORD_AXIS_PACKER -- requirements
Module: rx_word_axis_packer

Interface
REQ-001 Parameters SHALL be: FIFO_AW, 4, FIFO address width (depth 2^FIFO_AW words); CNT_W, 16, overflow counter width.
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 pkt_header_valid_strobe  in  1  one-cycle pulse marking start of a new packet.
REQ-005 pkt_len  in  16  packet length in bytes; valid with pkt_header_valid_strobe.
REQ-006 word_in  in  64  packed payload word.
REQ-007 word_in_strobe  in  1  one-cycle qualifier for word_in.
REQ-008 m_axis_tdata  out  64  output word.
REQ-009 m_axis_tvalid  out  1  output valid.
REQ-010 m_axis_tready  in  1  downstream ready.
REQ-011 m_axis_tlast  out  1  final word of packet.
REQ-012 m_axis_tuser  out  1  error terminator flag; 1 only on a synthetic terminator word.
REQ-013 fifo_level  out  FIFO_AW+1  current FIFO occupancy.
REQ-014 overflow_cnt  out  CNT_W  saturating count of packets dropped due to overflow or abort.

Function
REQ-015 Internal FIFO SHALL store entries {err, last, data}, 66 bits wide, depth 2^FIFO_AW, first-word-fall-through onto m_axis_*.
REQ-016 A transfer SHALL occur when m_axis_tvalid && m_axis_tready; m_axis_tvalid = FIFO not empty; tdata/tlast/tuser SHALL be stable while tvalid && !tready.
REQ-017 Push and pop in the same cycle SHALL leave fifo_level unchanged; push when full is never performed.
REQ-018 On header strobe, block SHALL latch num_word = (pkt_len+7)>>3 (17-bit arithmetic, no truncation) and clear word index to 0.
REQ-019 States SHALL be IDLE, RECV, DROP, TERM.
REQ-020 IDLE: word_in_strobe discarded; header with pkt_len != 0 -> RECV; header with pkt_len == 0 ignored, stay IDLE.
REQ-021 RECV: word_in_strobe with FIFO not full pushes {0, index==num_word-1, word_in}, index increments; after pushing last -> IDLE.
REQ-022 RECV: word_in_strobe with FIFO full drops the word, increments overflow_cnt, -> TERM.
REQ-023 TERM: pushes terminator {err=1, last=1, data=0} in the first cycle FIFO is not full, then -> DROP, or -> IDLE if the dropped or discarded span already covered index num_word-1; word_in_strobe in TERM is discarded but still advances index.
REQ-024 DROP: words discarded, index advances; on index reaching num_word -> IDLE.
REQ-025 Header strobe in RECV (incomplete packet) SHALL increment overflow_cnt, latch new num_word, and push a terminator before any word of the new packet; if FIFO full, enter TERM with a pending-restart flag so the new packet proceeds in RECV after the terminator.
REQ-026 Header strobe in DROP or TERM SHALL restart as in REQ-018 (TERM still emits its pending terminator first).
REQ-027 Header strobe and word_in_strobe in the same cycle: header wins, word discarded.
REQ-028 overflow_cnt SHALL saturate at all-ones, never wrap.
REQ-029 Latency: pushed word SHALL appear on m_axis_tvalid the cycle after the push when FIFO was empty.

Reset
REQ-030 rstn low SHALL asynchronously force: state IDLE, FIFO empty, fifo_level 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tuser 0, m_axis_tdata 0, overflow_cnt 0, index 0, num_word 0.
REQ-031 Reset mid-packet SHALL discard all buffered words; no terminator is emitted.
REQ-032 Release of rstn SHALL be synchronous to clk; first header accepted on the first edge after release.

Verification
REQ-033 pkt_len=20, 3 words, tready=1 -> 3 beats, tlast only on beat 3, tuser=0, overflow_cnt=0.
REQ-034 pkt_len=200 (25 words), FIFO_AW=4, tready=0 throughout -> 16 words buffered, word 17 dropped, overflow_cnt=1; after tready=1: 16 data beats, then terminator (data 0, tlast=1, tuser=1), 0 further beats.
REQ-035 Header pkt_len=24, 2 words sent, then header pkt_len=8 plus 1 word -> beats: w0, w1, terminator (tuser=1, tlast=1), new word (tlast=1, tuser=0); overflow_cnt=1.
REQ-036 Header pkt_len=0 followed by 2 word strobes -> no beats, fifo_level stays 0.
REQ-037 tready toggling 1/0 every cycle over pkt_len=64 -> 8 beats in order, tdata held during stalls, fifo_level never exceeds 8.
REQ-038 rstn asserted with 5 words buffered and tvalid=1 -> tvalid=0 and fifo_level=0 immediately, before next clk edge.
